// File: rtl/restoring_divider_64.sv
// rtl/restoring_divider_64.sv - radix-2 restoring unsigned divider, one quotient bit per clock
module restoring_divider_64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    // S_ZERO is a single holding cycle for a zero divisor so that done
    // arrives one edge after acceptance, without running any iterations.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ZERO = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    // The partial remainder is always below the divisor, so its extra sign
    // bit is always zero between steps and is not stored.
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    // On restore the trial value is below the divisor, so dropping its top bit is exact.
    always_comb begin
        trial = {r_reg, q_reg[WIDTH-1]};
        diff  = trial - {1'b0, d_reg};
        if (diff[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
        end else begin
            r_next = diff[WIDTH-1:0];
        end
        q_next = {q_reg[WIDTH-2:0], ~diff[WIDTH]};
    end

    // Control FSM, working registers and the held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        q_reg       <= dividend;
                        d_reg       <= divisor;
                        r_reg       <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            state <= S_ZERO;
                        end else begin
                            cnt   <= CW'(WIDTH - 1);
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    if (cnt == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_ZERO: begin
                    quotient    <= '1;
                    remainder   <= q_reg;
                    div_by_zero <= 1'b1;
                    state       <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_restoring_divider_64.sv
// tb/tb_restoring_divider_64.sv - scoreboard bench for restoring_divider_64
module tb_restoring_divider_64;
    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        ready;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    restoring_divider_64 #(.WIDTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ncyc     = 0;
    logic [63:0] hq = '0;
    logic [63:0] hr = '0;
    logic        hd = 1'b0;
    logic        prev_done = 1'b0;
    logic        prev_rst  = 1'b1;
    bit          b2b = 1'b0;
    bit          have_prev = 1'b0;
    int          prev_acc = 0;
    int          prev_lat = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: v = v >> $urandom_range(0, 63);
            1: v = 64'($urandom_range(0, 20));
            2: v = v | 64'h8000_0000_0000_0000;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] rnd_div();
        if ($urandom_range(0, 9) == 0) return 64'd0;
        return rnd64();
    endfunction

    // Reference model: plain unsigned division, zero divisor handled separately.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int acc);
        exp_t e;
        e.acc = acc;
        if (b == 64'd0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 2;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = 65;
        end
        return e;
    endfunction

    // Monitor: scores done cycles, output holding, and records accepted starts.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                chk("latency", 64'(ncyc - e.acc), 64'(e.lat));
                hq = e.q; hr = e.r; hd = e.dz;
            end
        end else begin
            chk("hold_quotient", quotient, hq);
            chk("hold_remainder", remainder, hr);
            chk("hold_div_by_zero", 64'(div_by_zero), 64'(hd));
        end
        if (prev_done && !prev_rst) chk("ready_after_done", 64'(ready), 64'd1);
        prev_done = done;
        prev_rst  = rst;
        if (rst) begin
            sb.delete();
            hq = '0; hr = '0; hd = 1'b0;
            have_prev = 1'b0;
        end else if (start && ready) begin
            e = model(dividend, divisor, ncyc);
            if (b2b && have_prev) chk("b2b_period", 64'(ncyc - prev_acc), 64'(prev_lat + 1));
            have_prev = 1'b1;
            prev_acc  = ncyc;
            prev_lat  = e.lat;
            sb.push_back(e);
            hd = 1'b0;
        end
    end

    // Wait for ready (bounded), present one start pulse, then scramble the operands.
    task automatic issue(input logic [63:0] a, input logic [63:0] b);
        int k;
        k = 0;
        while (!ready && k < 300) begin
            @(posedge clk); #2;
            k++;
        end
        if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #2;
        start = 1'b0; dividend = rnd64(); divisor = rnd64();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || !ready) && k < 500) begin
            @(posedge clk); #2;
            k++;
        end
        if (k >= 500) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    logic [63:0] bnd_a[4];
    logic [63:0] bnd_b[4];

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        bnd_a[0] = 64'd5;                   bnd_b[0] = 64'd9;
        bnd_a[1] = 64'hFFFF_FFFF_FFFF_FFFF; bnd_b[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        bnd_a[2] = 64'hFFFF_FFFF_FFFF_FFFF; bnd_b[2] = 64'h8000_0000_0000_0000;
        bnd_a[3] = 64'hFFFF_FFFF_FFFF_FFFF; bnd_b[3] = 64'd1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_quotient", quotient, 64'd0);
        chk("reset_remainder", remainder, 64'd0);
        chk("reset_div_by_zero", 64'(div_by_zero), 64'd0);

        issue(64'd100, 64'd7);
        chk("ready_low_after_start", 64'(ready), 64'd0);
        drain();

        issue(64'h1234, 64'd0);
        chk("ready_low_after_zero_start", 64'(ready), 64'd0);
        drain();

        for (int i = 0; i < 4; i++) begin
            issue(bnd_a[i], bnd_b[i]);
            drain();
        end

        // second start during RUN must be ignored
        issue(64'd100, 64'd7);
        repeat (9) @(posedge clk);
        #2 start = 1'b1; dividend = 64'd50; divisor = 64'd3;
        @(posedge clk); #2 start = 1'b0;
        repeat (5) begin
            @(posedge clk); #2 dividend = rnd64(); divisor = rnd64();
        end
        drain();
        repeat (10) @(posedge clk);
        #2;

        // reset mid-operation aborts with no done
        issue(64'd100, 64'd7);
        repeat (28) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_quotient", quotient, 64'd0);
        chk("abort_remainder", remainder, 64'd0);
        repeat (100) @(posedge clk);
        #2;
        issue(64'd81, 64'd9);
        drain();

        // start held high: back-to-back launches with changing operands
        b2b = 1'b1;
        have_prev = 1'b0;
        start = 1'b1;
        repeat (400) begin
            dividend = rnd64(); divisor = rnd_div();
            @(posedge clk); #2;
        end
        start = 1'b0;
        b2b = 1'b0;
        drain();

        // random regression
        for (int i = 0; i < 600; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            issue(rnd64(), rnd_div());
        end
        drain();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
